// File: rtl/comm_master_q_pkg.sv
// Shared types and constants for the queued UART command master.
// Holds the FSM state encoding and the command-width helper.
package comm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_e;

  localparam int UART_BITS        = 10;
  localparam int DEFAULT_BAUD_DIV = 2604;

  function automatic int bytes_per_cmd(input int cmd_w);
    return cmd_w / 8;
  endfunction

endpackage

// File: rtl/comm_master_q_if.sv
// Host-side command bus of the UART command master: push port, serial line and status.
interface comm_master_q_if #(
  parameter int CMD_W = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             snd_cmd;
  logic [CMD_W-1:0] cmd;
  logic             TX;
  logic             busy;
  logic             cmd_cmplt;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             ovf;

  modport master (
    output snd_cmd, cmd,
    input  TX, busy, cmd_cmplt, full, empty, count, ovf
  );

  modport slave (
    input  snd_cmd, cmd,
    output TX, busy, cmd_cmplt, full, empty, count, ovf
  );
endinterface

// File: rtl/comm_master_q_fifo.sv
// Circular command queue with wrap-around pointers and an occupancy counter.
module cmd_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[rptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/comm_master_q.sv
// Queued UART command master: serialises each queued word as NB 8N1 bytes.
// state | meaning: IDLE pop head | LOAD pick first byte | START start bit | DATA 8 bits LSB first | STOP stop bit
module comm_master_q
  import comm_pkg::*;
#(
  parameter int CMD_W     = 16,
  parameter int DEPTH     = 4,
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int MSB_FIRST = 1
) (
  input logic            clk,
  input logic            rst,
  comm_master_q_if.slave bus
);

  localparam int NB = bytes_per_cmd(CMD_W);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int YW = $clog2(NB) + 1;
  localparam int CW = $clog2(DEPTH + 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [YW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [CMD_W-1:0] shreg_q, shreg_d;
  logic [7:0]       cur_byte_q, cur_byte_d;
  logic             tx_q, tx_d, busy_q, busy_d, cmplt_q, cmplt_d, ovf_q, ovf_d;
  logic             push, pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_dout;
  logic [CW-1:0]    fifo_count;
  logic             baud_end, last_byte;

  function automatic logic [7:0] head_byte(input logic [CMD_W-1:0] s);
    return (MSB_FIRST != 0) ? s[CMD_W-1 -: 8] : s[7:0];
  endfunction

  function automatic logic [CMD_W-1:0] drop_byte(input logic [CMD_W-1:0] s);
    return (MSB_FIRST != 0) ? (s << 8) : (s >> 8);
  endfunction

  // full is the pre-pop value, so a slot freed this cycle is never reused in the same cycle
  assign push      = bus.snd_cmd && !fifo_full;
  assign baud_end  = (baud_q == BW'(BAUD_DIV - 1));
  assign last_byte = (byte_cnt_q == YW'(NB - 1));

  cmd_fifo #(.W(CMD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.cmd),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = LOAD;
      LOAD:    state_d = START;
      START:   if (baud_end) state_d = DATA;
      DATA:    if (baud_end && bit_q == 3'd7) state_d = STOP;
      STOP:    if (baud_end) state_d = last_byte ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Line outputs are registered from the current state, so they trail the FSM by one clock
  always_comb begin
    pop        = 1'b0;
    baud_d     = '0;
    bit_d      = bit_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    cur_byte_d = cur_byte_q;
    tx_d       = 1'b1;
    busy_d     = (state_q != IDLE);
    cmplt_d    = (state_q == IDLE) && busy_q;
    ovf_d      = bus.snd_cmd && fifo_full;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_dout;
        end
      end
      LOAD: begin
        byte_cnt_d = '0;
        cur_byte_d = head_byte(shreg_q);
        shreg_d    = drop_byte(shreg_q);
      end
      START: begin
        tx_d   = 1'b0;
        bit_d  = '0;
        baud_d = baud_end ? '0 : baud_q + 1'b1;
      end
      DATA: begin
        tx_d   = cur_byte_q[bit_q];
        baud_d = baud_end ? '0 : baud_q + 1'b1;
        if (baud_end) bit_d = (bit_q == 3'd7) ? 3'd0 : bit_q + 3'd1;
      end
      STOP: begin
        baud_d = baud_end ? '0 : baud_q + 1'b1;
        if (baud_end && !last_byte) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          cur_byte_d = head_byte(shreg_q);
          shreg_d    = drop_byte(shreg_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_q     <= '0;
      bit_q      <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      cur_byte_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      cmplt_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      cur_byte_q <= cur_byte_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      cmplt_q    <= cmplt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.TX        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.cmd_cmplt = cmplt_q;
  assign bus.ovf       = ovf_q;
  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.count     = fifo_count;

endmodule

// File: tb/tb_comm_master_q.sv
// Directed bench for comm_master_q: three instances cover MSB-first, LSB-first and 32-bit modes.
module tb_comm_master_q;
  import comm_pkg::*;

  localparam int BD        = 16;
  localparam int DEP       = 4;
  localparam int BYTE_CLKS = UART_BITS * BD;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   cmplt_a = 0, ovf_a = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comm_master_q_if #(.CMD_W(16), .DEPTH(DEP)) bus_a ();
  comm_master_q_if #(.CMD_W(16), .DEPTH(DEP)) bus_b ();
  comm_master_q_if #(.CMD_W(32), .DEPTH(DEP)) bus_c ();

  comm_master_q #(.CMD_W(16), .DEPTH(DEP), .BAUD_DIV(BD), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  comm_master_q #(.CMD_W(16), .DEPTH(DEP), .BAUD_DIV(BD), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));
  comm_master_q #(.CMD_W(32), .DEPTH(DEP), .BAUD_DIV(BD), .MSB_FIRST(1)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c));

  always @(negedge clk) begin
    if (bus_a.cmd_cmplt === 1'b1) cmplt_a <= cmplt_a + 1;
    if (bus_a.ovf === 1'b1)       ovf_a   <= ovf_a + 1;
  end

  function automatic logic tx_of(input int sel);
    case (sel)
      0:       return bus_a.TX;
      1:       return bus_b.TX;
      default: return bus_c.TX;
    endcase
  endfunction

  function automatic logic cmplt_of(input int sel);
    case (sel)
      0:       return bus_a.cmd_cmplt;
      1:       return bus_b.cmd_cmplt;
      default: return bus_c.cmd_cmplt;
    endcase
  endfunction

  task automatic set_in(input int sel, input logic snd, input logic [31:0] w);
    case (sel)
      0:       begin bus_a.snd_cmd = snd; bus_a.cmd = w[15:0]; end
      1:       begin bus_b.snd_cmd = snd; bus_b.cmd = w[15:0]; end
      default: begin bus_c.snd_cmd = snd; bus_c.cmd = w; end
    endcase
  endtask

  // Waits for a start bit, then samples each bit mid-period; fall = -1 if no start bit arrived.
  task automatic rx_byte(input int sel, output logic [7:0] b, output int fall, output logic stopb);
    int n;
    n = 0;
    b = '0;
    fall = -1;
    while (tx_of(sel) !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (tx_of(sel) === 1'b0) fall = cyc;
    repeat (BD / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(negedge clk);
      b[i] = tx_of(sel);
    end
    repeat (BD) @(negedge clk);
    stopb = tx_of(sel);
  endtask

  task automatic wait_cmplt(input int sel, output int c);
    int n;
    n = 0;
    c = -1;
    while (cmplt_of(sel) !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cmplt_of(sel) === 1'b1) c = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(0, 1'b0, 32'h0);
    set_in(1, 1'b0, 32'h0);
    set_in(2, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    total++; if (bus_a.TX !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b expected 1", bus_a.TX); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus_a.busy); end
    total++; if (bus_a.cmd_cmplt !== 1'b0) begin bad++; $display("FAIL reset_cmplt: got %b expected 0", bus_a.cmd_cmplt); end
    total++; if (bus_a.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b expected 0", bus_a.ovf); end
    total++; if (bus_a.count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", bus_a.count); end
    total++; if (bus_a.empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b expected 1", bus_a.empty); end
    total++; if (bus_a.full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b expected 0", bus_a.full); end
    total++; if (bus_c.TX !== 1'b1) begin bad++; $display("FAIL reset_tx_wide: got %b expected 1", bus_c.TX); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] b0, b1;
    logic       s0, s1;
    int         f0, f1, c, t, n0;
    n0 = cmplt_a;
    set_in(0, 1'b1, 32'hA503);
    t = cyc + 1;
    @(negedge clk);
    set_in(0, 1'b0, 32'h0);
    rx_byte(0, b0, f0, s0);
    total++; if (bus_a.busy !== 1'b1) begin bad++; $display("FAIL single_busy_mid: got %b expected 1", bus_a.busy); end
    rx_byte(0, b1, f1, s1);
    wait_cmplt(0, c);
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL single_busy_drop: got %b expected 0", bus_a.busy); end
    total++; if (f0 !== t + 3) begin bad++; $display("FAIL single_latency: got %0d expected %0d", f0, t + 3); end
    total++; if (b0 !== 8'hA5) begin bad++; $display("FAIL single_byte0: got %h expected a5", b0); end
    total++; if (b1 !== 8'h03) begin bad++; $display("FAIL single_byte1: got %h expected 03", b1); end
    total++; if ({s0, s1} !== 2'b11) begin bad++; $display("FAIL single_stop: got %b expected 11", {s0, s1}); end
    total++; if (f1 !== f0 + BYTE_CLKS) begin bad++; $display("FAIL single_byte_gap: got %0d expected %0d", f1 - f0, BYTE_CLKS); end
    total++; if (c !== f0 + 2 * BYTE_CLKS) begin bad++; $display("FAIL single_cmplt_time: got %0d expected %0d", c - f0, 2 * BYTE_CLKS); end
    @(negedge clk);
    total++; if (bus_a.cmd_cmplt !== 1'b0) begin bad++; $display("FAIL single_cmplt_width: got %b expected 0", bus_a.cmd_cmplt); end
    repeat (3) @(negedge clk);
    total++; if (cmplt_a - n0 !== 1) begin bad++; $display("FAIL single_cmplt_count: got %0d expected 1", cmplt_a - n0); end
  endtask

  task automatic test_order();
    logic [7:0] b0, b1;
    logic       s0, s1;
    int         f0, f1, c;
    set_in(1, 1'b1, 32'h1234);
    @(negedge clk);
    set_in(1, 1'b0, 32'h0);
    rx_byte(1, b0, f0, s0);
    rx_byte(1, b1, f1, s1);
    wait_cmplt(1, c);
    total++; if (b0 !== 8'h34) begin bad++; $display("FAIL order_byte0: got %h expected 34", b0); end
    total++; if (b1 !== 8'h12) begin bad++; $display("FAIL order_byte1: got %h expected 12", b1); end
    total++; if (c !== f0 + 2 * BYTE_CLKS) begin bad++; $display("FAIL order_cmplt_time: got %0d expected %0d", c - f0, 2 * BYTE_CLKS); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0, b1;
    logic       s0, s1;
    int         f0, f1, c, cprev, fprev, t, peak, o0;
    peak = 0;
    cprev = 0;
    fprev = 0;
    o0 = ovf_a;
    t = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1'b1, 32'(k + 1));
      @(negedge clk);
      if (int'(bus_a.count) > peak) peak = int'(bus_a.count);
    end
    set_in(0, 1'b0, 32'h0);
    for (int w = 0; w < 4; w++) begin
      rx_byte(0, b0, f0, s0);
      rx_byte(0, b1, f1, s1);
      wait_cmplt(0, c);
      total++; if ({b0, b1} !== 16'(w + 1)) begin bad++; $display("FAIL burst_word%0d: got %h expected %h", w, {b0, b1}, 16'(w + 1)); end
      if (w == 0) begin
        total++; if (f0 !== t + 3) begin bad++; $display("FAIL burst_latency: got %0d expected %0d", f0, t + 3); end
      end else begin
        total++; if (c - cprev !== 322) begin bad++; $display("FAIL burst_cmplt_gap%0d: got %0d expected 322", w, c - cprev); end
        total++; if (f0 - fprev !== 322) begin bad++; $display("FAIL burst_start_gap%0d: got %0d expected 322", w, f0 - fprev); end
      end
      cprev = c;
      fprev = f0;
    end
    total++; if (peak !== 3) begin bad++; $display("FAIL burst_peak_count: got %0d expected 3", peak); end
    repeat (3) @(negedge clk);
    total++; if (ovf_a - o0 !== 0) begin bad++; $display("FAIL burst_ovf: got %0d expected 0", ovf_a - o0); end
  endtask

  task automatic test_overflow();
    logic [7:0] b0, b1;
    logic       s0, s1;
    int         f0, f1, c, o0, n0;
    logic [2:0] cnt4;
    logic       full4, ovf4, ovf5;
    o0 = ovf_a;
    n0 = cmplt_a;
    cnt4 = '0; full4 = 1'b0; ovf4 = 1'b0; ovf5 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_in(0, 1'b1, 32'(16'h0011 + k));
      @(negedge clk);
      if (k == 4) begin cnt4 = bus_a.count; full4 = bus_a.full; ovf4 = bus_a.ovf; end
      if (k == 5) ovf5 = bus_a.ovf;
    end
    set_in(0, 1'b0, 32'h0);
    total++; if (cnt4 !== 3'd4) begin bad++; $display("FAIL ovf_count_full: got %0d expected 4", cnt4); end
    total++; if (full4 !== 1'b1) begin bad++; $display("FAIL ovf_full_flag: got %b expected 1", full4); end
    total++; if ({ovf4, ovf5} !== 2'b01) begin bad++; $display("FAIL ovf_pulse_time: got %b expected 01", {ovf4, ovf5}); end
    for (int w = 0; w < 5; w++) begin
      rx_byte(0, b0, f0, s0);
      rx_byte(0, b1, f1, s1);
      wait_cmplt(0, c);
      total++; if ({b0, b1} !== 16'(16'h0011 + w)) begin bad++; $display("FAIL ovf_word%0d: got %h expected %h", w, {b0, b1}, 16'(16'h0011 + w)); end
    end
    repeat (40) @(negedge clk);
    total++; if (ovf_a - o0 !== 1) begin bad++; $display("FAIL ovf_pulses: got %0d expected 1", ovf_a - o0); end
    total++; if (cmplt_a - n0 !== 5) begin bad++; $display("FAIL ovf_words_sent: got %0d expected 5", cmplt_a - n0); end
    total++; if ({bus_a.busy, bus_a.empty, bus_a.TX} !== 3'b011) begin bad++; $display("FAIL ovf_drained: got %b expected 011", {bus_a.busy, bus_a.empty, bus_a.TX}); end
  endtask

  task automatic test_wide();
    logic [7:0]  b [4];
    logic        s;
    int          f [4];
    int          c;
    logic [31:0] got;
    set_in(2, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    set_in(2, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) rx_byte(2, b[i], f[i], s);
    wait_cmplt(2, c);
    got = {b[0], b[1], b[2], b[3]};
    total++; if (got !== 32'hDEADBEEF) begin bad++; $display("FAIL wide_bytes: got %h expected deadbeef", got); end
    for (int i = 1; i < 4; i++) begin
      total++; if (f[i] - f[i-1] !== BYTE_CLKS) begin bad++; $display("FAIL wide_gap%0d: got %0d expected %0d", i, f[i] - f[i-1], BYTE_CLKS); end
    end
    total++; if (c - f[0] !== 4 * BYTE_CLKS) begin bad++; $display("FAIL wide_cmplt_time: got %0d expected %0d", c - f[0], 4 * BYTE_CLKS); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] b0, b1;
    logic       s0, s1;
    int         f0, f1, c, n0, n, lows;
    set_in(0, 1'b1, 32'h5AC3);
    @(negedge clk);
    set_in(0, 1'b1, 32'h1111);
    @(negedge clk);
    set_in(0, 1'b0, 32'h0);
    rx_byte(0, b0, f0, s0);
    n = 0;
    while (bus_a.TX !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    total++; if (bus_a.TX !== 1'b0) begin bad++; $display("FAIL rmid_second_start: got %b expected 0", bus_a.TX); end
    repeat (BD / 2 + 3 * BD) @(negedge clk);
    n0 = cmplt_a;
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus_a.TX !== 1'b1) begin bad++; $display("FAIL rmid_tx: got %b expected 1", bus_a.TX); end
    total++; if (bus_a.count !== 3'd0) begin bad++; $display("FAIL rmid_count: got %0d expected 0", bus_a.count); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b expected 0", bus_a.busy); end
    total++; if (bus_a.empty !== 1'b1) begin bad++; $display("FAIL rmid_empty: got %b expected 1", bus_a.empty); end
    rst = 1'b0;
    lows = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus_a.TX !== 1'b1) lows++;
    end
    total++; if (lows !== 0) begin bad++; $display("FAIL rmid_flushed: got %0d low cycles expected 0", lows); end
    total++; if (cmplt_a - n0 !== 0) begin bad++; $display("FAIL rmid_no_cmplt: got %0d expected 0", cmplt_a - n0); end
    set_in(0, 1'b1, 32'hC35A);
    @(negedge clk);
    set_in(0, 1'b0, 32'h0);
    rx_byte(0, b0, f0, s0);
    rx_byte(0, b1, f1, s1);
    wait_cmplt(0, c);
    total++; if ({b0, b1} !== 16'hC35A) begin bad++; $display("FAIL rmid_after_word: got %h expected c35a", {b0, b1}); end
    total++; if (c - f0 !== 2 * BYTE_CLKS) begin bad++; $display("FAIL rmid_after_cmplt: got %0d expected %0d", c - f0, 2 * BYTE_CLKS); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_order();
    test_back_to_back();
    test_overflow();
    test_wide();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/comm_master_q.md
Name: comm_master_q

Overview:
- Parametrised successor to the single-command UART command master that drives travel-plan words into MazeRunner's RX line.
- Accepts command words of configurable width into a DEPTH-entry queue, so a bench or host can post a whole travel plan without waiting.
- Serialises each queued word as a sequence of 8N1 UART bytes at a configurable baud divisor.
- Reports per-command completion, queue occupancy and overflow.

Parameters:
- CMD_W, 16, command width in bits; must be a multiple of 8. NB = CMD_W/8 bytes per command.
- DEPTH, 4, queue entries; power of 2, >= 2.
- BAUD_DIV, 2604, clocks per UART bit (50 MHz / 19200).
- MSB_FIRST, 1, byte order: 1 sends the most significant byte first, 0 sends the least significant byte first.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- snd_cmd  in  1  push request; one word per asserted cycle
- cmd  in  CMD_W  command word, sampled when snd_cmd=1
- TX  out  1  UART serial line, idles high
- busy  out  1  high while a command is being serialised
- cmd_cmplt  out  1  one-cycle pulse when a command's last stop bit ends
- full  out  1  count==DEPTH
- empty  out  1  count==0
- count  out  $clog2(DEPTH+1)  queued words, excluding the one in flight
- ovf  out  1  one-cycle pulse when a push is dropped

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: TX=1, busy=0, cmd_cmplt=0, ovf=0, count=0, empty=1, full=0, FSM in IDLE.
- Reset mid-transmission: TX returns high on the next edge, the queue is flushed, and no cmd_cmplt is generated.

Queue:
- Circular buffer with wrap-around read/write pointers.
- A push occurs when snd_cmd=1 and full=0.
- If snd_cmd=1 and full=1, the word is dropped and ovf pulses. full is evaluated before a same-cycle pop, so a push is never accepted into a slot that is being freed in that cycle.
- A simultaneous push and pop leaves count unchanged.

FSM states: IDLE, LOAD, START, DATA, STOP.
- IDLE: TX=1, busy=0. If empty=0, pop the head word into a CMD_W shift register and go to LOAD.
- LOAD: select the next byte by MSB_FIRST; reset byte counter to 0; busy=1; go to START.
- START: TX=0 for BAUD_DIV clocks, then go to DATA.
- DATA: 8 bits, LSB first, each held BAUD_DIV clocks, then go to STOP.
- STOP: TX=1 for BAUD_DIV clocks. Then:
  - if the byte counter < NB-1: increment it, shift in the next byte and go directly to START (no idle gap between bytes);
  - otherwise: pulse cmd_cmplt and go to IDLE.
- busy stays high from LOAD through the end of the last STOP.

Latency and timing:
- With an empty queue and FSM in IDLE, snd_cmd sampled at edge t gives TX=0 starting at edge t+3 (push t, pop t+1, LOAD t+2).
- One command occupies NB*10*BAUD_DIV clocks of line time.
- Consecutive queued commands are separated by exactly 2 idle-high clocks (IDLE and LOAD).

Counters and widths:
- Baud counter: $clog2(BAUD_DIV) bits; bit period ends at count BAUD_DIV-1.
- Bit counter: 3 bits. Byte counter: $clog2(NB)+1 bits.
- Counters wrap only through explicit clears; there is no free-running overflow.

Decomposition:
- Package comm_pkg holds:
  - the state enum (IDLE, LOAD, START, DATA, STOP);
  - localparams UART_BITS=10 and DEFAULT_BAUD_DIV=2604;
  - a function bytes_per_cmd(CMD_W).
- One sub-module, cmd_fifo (parameters W, DEPTH; ports push, pop, din, dout, full, empty, count). The top module holds the FSM and serialiser.

Test Plan (BAUD_DIV=16 for simulation):
- Single word, CMD_W=16, cmd=16'hA503, MSB_FIRST=1 -> TX falls at edge t+3; bytes decode as A5 then 03; each byte is 160 clocks; cmd_cmplt pulses once, 320 clocks after TX first falls; busy drops in the same cycle.
- Byte order, MSB_FIRST=0, cmd=16'h1234 -> decoded bytes are 34 then 12.
- Queue burst: 4 back-to-back snd_cmd with 0001, 0002, 0003, 0004 at DEPTH=4 -> count peaks at 3 (first word popped), no ovf; four cmd_cmplt pulses, each 322 clocks apart; words decoded in order.
- Overflow: 6 pushes in 6 consecutive cycles at DEPTH=4 -> one word in flight, 4 queued, one dropped; ovf pulses exactly once; 5 words are transmitted.
- Wide mode, CMD_W=32, cmd=32'hDEADBEEF -> bytes DE, AD, BE, EF sent with no inter-byte gap; one cmd_cmplt at 640 clocks.
- Reset mid-DATA of the second byte -> next edge gives TX=1, count=0, busy=0, no cmd_cmplt; a subsequent push transmits normally.
